// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port video RAM between the CPU
// external-memory path and the video scanout fetcher. Video has priority;
// the CPU wins once CPU_STARVE_MAX video grants have passed it by.
// Optional feature macro: VRAM_ARB_OVERRUN_EN (sticky vidOverrun flag).
// Handshake: cpuReq is a level held until the one-cycle cpuAck pulse;
// vidReq is a one-cycle pulse answered by a one-cycle vidValid pulse.
module vram_arbiter #(
  parameter int ADDR_W         = 11,
  parameter int CPU_STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpuReq,
  input  logic              cpuWrite,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [7:0]        cpuWdata,
  output logic [7:0]        cpuRdata,
  output logic              cpuAck,
  input  logic              vidReq,
  input  logic [ADDR_W-1:0] vidAddr,
  output logic [7:0]        vidData,
  output logic              vidValid,
  output logic              vidOverrun,
  input  logic              vidOverrunClr,
  output logic              ramEn,
  output logic              ramWe,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [7:0]        ramWdata,
  input  logic [7:0]        ramRdata
);

  localparam logic [3:0] STARVE_LIM = 4'(CPU_STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state, state_next;
  logic                vid_pend;
  logic [ADDR_W-1:0]   vid_addr_q;
  logic [3:0]          starve_cnt;
  logic                owner_cpu;
  logic                owner_write;

  logic                arb;
  logic                cpu_elig;
  logic                vid_avail;
  logic [ADDR_W-1:0]   vid_grant_addr;
  logic                vid_win;
  logic                cpu_win;
  logic                overrun_evt;

  // Arbitration and next-state decode; a fresh vidReq competes in the same cycle
  always_comb begin
    state_next     = state;
    arb            = (state == IDLE) || (state == RESP);
    // A held cpuReq must not be re-granted while its access is finishing
    cpu_elig       = cpuReq && !((state == RESP) && owner_cpu) && !cpuAck;
    vid_avail      = vid_pend || vidReq;
    vid_grant_addr = vid_pend ? vid_addr_q : vidAddr;
    vid_win        = arb && vid_avail && !((starve_cnt >= STARVE_LIM) && cpu_elig);
    cpu_win        = arb && !vid_win && cpu_elig;
    // A pending fetch that is not served now gets its address overwritten
    overrun_evt    = vidReq && vid_pend && !vid_win;
    case (state)
      IDLE:    state_next = (vid_win || cpu_win) ? ACCESS : IDLE;
      ACCESS:  state_next = RESP;
      RESP:    state_next = (vid_win || cpu_win) ? ACCESS : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Video capture, starvation count, grant registration and completion
  always_ff @(posedge clk) begin
    if (reset) begin
      vid_pend    <= 1'b0;
      vid_addr_q  <= '0;
      starve_cnt  <= 4'd0;
      owner_cpu   <= 1'b0;
      owner_write <= 1'b0;
      ramEn       <= 1'b0;
      ramWe       <= 1'b0;
      ramAddr     <= '0;
      ramWdata    <= 8'd0;
      cpuRdata    <= 8'd0;
      cpuAck      <= 1'b0;
      vidData     <= 8'd0;
      vidValid    <= 1'b0;
    end else begin
      // A vidReq granted straight from the input never becomes pending
      if (vidReq && !(vid_win && !vid_pend)) begin
        vid_pend   <= 1'b1;
        vid_addr_q <= vidAddr;
      end else if (vid_win) begin
        vid_pend <= 1'b0;
      end

      if (arb) begin
        if (!cpu_elig || cpu_win)
          starve_cnt <= 4'd0;
        else if (vid_win && (starve_cnt != 4'hF))
          starve_cnt <= starve_cnt + 4'd1;
      end

      ramEn <= vid_win || cpu_win;
      ramWe <= cpu_win && cpuWrite;
      if (vid_win) begin
        ramAddr     <= vid_grant_addr;
        owner_cpu   <= 1'b0;
        owner_write <= 1'b0;
      end else if (cpu_win) begin
        ramAddr     <= cpuAddr;
        ramWdata    <= cpuWdata;
        owner_cpu   <= 1'b1;
        owner_write <= cpuWrite;
      end

      cpuAck   <= 1'b0;
      vidValid <= 1'b0;
      if (state == RESP) begin
        if (owner_cpu) begin
          cpuAck <= 1'b1;
          if (!owner_write) cpuRdata <= ramRdata;
        end else begin
          vidValid <= 1'b1;
          vidData  <= ramRdata;
        end
      end
    end
  end

`ifdef VRAM_ARB_OVERRUN_EN
  // Sticky overrun flag; a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (reset)              vidOverrun <= 1'b0;
    else if (overrun_evt)   vidOverrun <= 1'b1;
    else if (vidOverrunClr) vidOverrun <= 1'b0;
  end
`else
  assign vidOverrun = 1'b0;
  logic unused_overrun;
  assign unused_overrun = overrun_evt ^ vidOverrunClr;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_vram_arbiter;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpuReq, cpuWrite;
  logic [AW-1:0] cpuAddr;
  logic [7:0]    cpuWdata, cpuRdata;
  logic          cpuAck;
  logic          vidReq;
  logic [AW-1:0] vidAddr;
  logic [7:0]    vidData;
  logic          vidValid, vidOverrun, vidOverrunClr;
  logic          ramEn, ramWe;
  logic [AW-1:0] ramAddr;
  logic [7:0]    ramWdata, ramRdata;

  int total = 0;
  int bad   = 0;

  // clock
  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .CPU_STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpuReq(cpuReq), .cpuWrite(cpuWrite), .cpuAddr(cpuAddr),
    .cpuWdata(cpuWdata), .cpuRdata(cpuRdata), .cpuAck(cpuAck),
    .vidReq(vidReq), .vidAddr(vidAddr), .vidData(vidData),
    .vidValid(vidValid), .vidOverrun(vidOverrun), .vidOverrunClr(vidOverrunClr),
    .ramEn(ramEn), .ramWe(ramWe), .ramAddr(ramAddr),
    .ramWdata(ramWdata), .ramRdata(ramRdata)
  );

  // RAM model: synchronous, read data valid the cycle after the command
  logic [7:0] mem [0:2047];
  logic [7:0] rd_q = 8'd0;
  assign ramRdata = rd_q;
  always @(posedge clk) begin
    if (ramEn) begin
      if (ramWe) mem[ramAddr] = ramWdata;
      else       rd_q <= mem[ramAddr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Four video grants with the CPU waiting, then one CPU override grant.
  // With ovr set, a second vidReq lands during the CPU access and overwrites.
  task automatic starve_round(input bit ovr);
    logic [AW-1:0] last_addr;
    logic [7:0]    last_byte;
    logic          exp_valid;
    logic          exp_ovr;
    last_addr = ovr ? 11'h010 : 11'h304;
    last_byte = ovr ? 8'h3C : 8'hA4;
    cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddr = 11'h200;
    vidReq = 1'b1; vidAddr = 11'h300;
    for (int t = 1; t <= 14; t++) begin
      tick;
      vidReq = 1'b0;
      if (t == 2 || t == 4 || t == 6 || t == 8) begin
        vidReq  = 1'b1;
        vidAddr = 11'h300 + 11'(t / 2);
      end
      if (ovr && t == 9) begin
        vidReq  = 1'b1;
        vidAddr = 11'h010;
      end
      if (t == 11) cpuReq = 1'b0;
      vidOverrunClr = (t == 13);

      chk($sformatf("st_ram_en_t%0d", t), 32'(ramEn), 32'((t % 2 == 1) && (t <= 11)));
      if (t <= 7 && (t % 2 == 1))
        chk($sformatf("st_ram_addr_t%0d", t), 32'(ramAddr), 32'(11'h300 + 11'((t - 1) / 2)));
      if (t == 9)  chk("st_ram_addr_cpu", 32'(ramAddr), 32'h200);
      if (t == 11) chk("st_ram_addr_last", 32'(ramAddr), 32'(last_addr));

      exp_valid = (t == 3 || t == 5 || t == 7 || t == 9 || t == 13);
      chk($sformatf("st_vid_valid_t%0d", t), 32'(vidValid), 32'(exp_valid));
      if (exp_valid && t <= 9)
        chk($sformatf("st_vid_data_t%0d", t), 32'(vidData), 32'(8'hA0 + 8'((t - 3) / 2)));
      if (t == 13) chk("st_vid_data_last", 32'(vidData), 32'(last_byte));

      chk($sformatf("st_cpu_ack_t%0d", t), 32'(cpuAck), 32'(t == 11));
      if (t == 11) chk("st_cpu_rdata", 32'(cpuRdata), 32'h77);

`ifdef VRAM_ARB_OVERRUN_EN
      exp_ovr = ovr;
`else
      exp_ovr = 1'b0;
`endif
      if (t == 12) chk("st_overrun_set", 32'(vidOverrun), 32'(exp_ovr));
      if (t == 14) chk("st_overrun_clr", 32'(vidOverrun), 32'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
    mem[11'h7FF] = 8'hC3;
    mem[11'h200] = 8'h77;
    mem[11'h010] = 8'h3C;
    for (int k = 0; k < 5; k++) mem[11'h300 + k] = 8'hA0 + 8'(k);

    reset = 1'b1; cpuReq = 1'b0; cpuWrite = 1'b0; cpuAddr = '0; cpuWdata = 8'd0;
    vidReq = 1'b0; vidAddr = '0; vidOverrunClr = 1'b0;
    tick;
    tick;
    // reset state
    chk("rst_cpu_ack",   32'(cpuAck),     32'h0);
    chk("rst_vid_valid", 32'(vidValid),   32'h0);
    chk("rst_ram_en",    32'(ramEn),      32'h0);
    chk("rst_ram_we",    32'(ramWe),      32'h0);
    chk("rst_ram_addr",  32'(ramAddr),    32'h0);
    chk("rst_overrun",   32'(vidOverrun), 32'h0);
    chk("rst_cpu_rdata", 32'(cpuRdata),   32'h0);
    reset = 1'b0;

    // CPU write 0x5A to 0x123
    cpuReq = 1'b1; cpuWrite = 1'b1; cpuAddr = 11'h123; cpuWdata = 8'h5A;
    tick;
    chk("wr_ram_en",    32'(ramEn),    32'h1);
    chk("wr_ram_we",    32'(ramWe),    32'h1);
    chk("wr_ram_addr",  32'(ramAddr),  32'h123);
    chk("wr_ram_wdata", 32'(ramWdata), 32'h5A);
    tick;
    chk("wr_ack_early", 32'(cpuAck), 32'h0);
    chk("wr_ram_en_resp", 32'(ramEn), 32'h0);
    tick;
    chk("wr_ack", 32'(cpuAck), 32'h1);
    chk("wr_rdata_kept", 32'(cpuRdata), 32'h0);
    cpuReq = 1'b0;
    tick;
    chk("wr_ack_single", 32'(cpuAck), 32'h0);

    // CPU read back 0x123
    cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddr = 11'h123;
    tick;
    chk("rd_ram_we", 32'(ramWe), 32'h0);
    chk("rd_ram_en", 32'(ramEn), 32'h1);
    tick;
    tick;
    chk("rd_ack",   32'(cpuAck),   32'h1);
    chk("rd_rdata", 32'(cpuRdata), 32'h5A);
    cpuReq = 1'b0;
    tick;

    // Video alone at 0x7FF
    vidReq = 1'b1; vidAddr = 11'h7FF;
    tick;
    vidReq = 1'b0;
    chk("vid_ram_addr", 32'(ramAddr), 32'h7FF);
    chk("vid_ram_we",   32'(ramWe),   32'h0);
    tick;
    chk("vid_valid_early", 32'(vidValid), 32'h0);
    tick;
    chk("vid_valid",   32'(vidValid), 32'h1);
    chk("vid_data",    32'(vidData),  32'hC3);
    chk("vid_cpu_ack", 32'(cpuAck),   32'h0);
    tick;
    chk("vid_valid_single", 32'(vidValid), 32'h0);

    // Simultaneous CPU read of 0x123 and video fetch of 0x7FF
    cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddr = 11'h123;
    vidReq = 1'b1; vidAddr = 11'h7FF;
    tick;
    vidReq = 1'b0;
    chk("sim_first_addr", 32'(ramAddr), 32'h7FF);
    tick;
    tick;
    chk("sim_vid_valid",   32'(vidValid), 32'h1);
    chk("sim_second_addr", 32'(ramAddr),  32'h123);
    chk("sim_second_en",   32'(ramEn),    32'h1);
    tick;
    chk("sim_ack_early", 32'(cpuAck), 32'h0);
    tick;
    chk("sim_cpu_ack",   32'(cpuAck),   32'h1);
    chk("sim_cpu_rdata", 32'(cpuRdata), 32'h5A);
    cpuReq = 1'b0;
    tick;

    // Starvation rounds: plain, then with an overrun during the CPU access
    starve_round(1'b0);
    starve_round(1'b1);

    // Reset during RESP of a CPU read
    cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddr = 11'h123;
    tick;
    chk("rr_ram_en", 32'(ramEn), 32'h1);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0; cpuReq = 1'b0;
    chk("rr_cpu_ack",   32'(cpuAck),   32'h0);
    chk("rr_cpu_rdata", 32'(cpuRdata), 32'h0);
    chk("rr_vid_data",  32'(vidData),  32'h0);
    chk("rr_ram_en",    32'(ramEn),    32'h0);
    chk("rr_ram_addr",  32'(ramAddr),  32'h0);
    tick;
    chk("rr_no_late_ack", 32'(cpuAck), 32'h0);
    cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddr = 11'h7FF;
    tick;
    chk("rr_new_addr", 32'(ramAddr), 32'h7FF);
    tick;
    tick;
    chk("rr_new_ack",   32'(cpuAck),   32'h1);
    chk("rr_new_rdata", 32'(cpuRdata), 32'hC3);
    cpuReq = 1'b0;
    tick;
    chk("rr_new_ack_single", 32'(cpuAck), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
